// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl_if
// Description : Load/result bus of the iterative AES-128 sequencer.
//               master : block source (drives load/key/plaintext)
//               slave  : sequencer    (drives busy/done/cyphertext/round_idx)
//   load        1    start request
//   key         128  cipher key
//   plaintext   128  input block
//   busy        1    block in flight
//   done        1    cyphertext valid (level)
//   cyphertext  128  result block
//   round_idx   4    current round number
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if;
  logic         load;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;
  logic [127:0] cyphertext;
  logic [3:0]   round_idx;

  modport master (
    output load, key, plaintext,
    input  busy, done, cyphertext, round_idx
  );

  modport slave (
    input  load, key, plaintext,
    output busy, done, cyphertext, round_idx
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Iterative AES-128 encryption sequencer. Owns the state and
//               round-key registers and steps subBytes, shiftRows,
//               mixColumns, addRoundKey and one key-expansion step per round.
//   clk    in   rising-edge clock
//   nreset in   asynchronous active-low reset
//   bus    slave modport of aes_round_ctrl_if (load/key/plaintext in,
//               busy/done/cyphertext/round_idx out)
//   NR        number of rounds (10 for AES-128)
//   SBOX_SYNC 1: registered S-box stage (2 cycles/round), 0: 1 cycle/round
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int NR        = 10,
  parameter bit SBOX_SYNC = 1'b1
) (
  input  logic           clk,
  input  logic           nreset,
  aes_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SB    = 3'd2;
  localparam logic [2:0] S_RND   = 3'd3;
  localparam logic [2:0] S_FINAL = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] NR_IDX = 4'(NR);

  // Listed from input 0x00 upward; stored at index 255-x so lookup is SBOX[~x].
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox(w[8*i +: 8]);
    return r;
  endfunction

  // Byte n sits at bits [127-8n -: 8]; n = row + 4*column.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[127-32*col -: 8];
      a1 = s[119-32*col -: 8];
      a2 = s[111-32*col -: 8];
      a3 = s[103-32*col -: 8];
      r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  logic [2:0]   fsm_q, fsm_d;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_idx_q;
  logic [127:0] cyph_q;

  logic [127:0] sb_state;   // subBytes(state) feeding the round
  logic [31:0]  sub_rot;    // SubWord(RotWord(last key word))
  logic [31:0]  ks_temp, ks_w0, ks_w1, ks_w2, ks_w3;
  logic [127:0] next_rk;
  logic [127:0] sr_state;
  logic [127:0] mc_state;
  logic [127:0] round_out;

  generate
    if (SBOX_SYNC) begin : g_sbox_sync
      logic [127:0] sb_state_q;
      logic [31:0]  sub_rot_q;
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          sb_state_q <= '0;
          sub_rot_q  <= '0;
        end else if (fsm_q == S_SB) begin
          sb_state_q <= sub_bytes(state_q);
          sub_rot_q  <= sub_word({rk_q[23:0], rk_q[31:24]});
        end
      end
      assign sb_state = sb_state_q;
      assign sub_rot  = sub_rot_q;
    end else begin : g_sbox_comb
      assign sb_state = sub_bytes(state_q);
      assign sub_rot  = sub_word({rk_q[23:0], rk_q[31:24]});
    end
  endgenerate

  // One key-expansion step: four new words from the current round key.
  assign ks_temp = sub_rot ^ {rcon_q, 24'h000000};
  assign ks_w0   = rk_q[127:96] ^ ks_temp;
  assign ks_w1   = rk_q[95:64]  ^ ks_w0;
  assign ks_w2   = rk_q[63:32]  ^ ks_w1;
  assign ks_w3   = rk_q[31:0]   ^ ks_w2;
  assign next_rk = {ks_w0, ks_w1, ks_w2, ks_w3};

  assign sr_state  = shift_rows(sb_state);
  assign mc_state  = (fsm_q == S_FINAL) ? sr_state : mix_columns(sr_state);
  assign round_out = mc_state ^ next_rk;

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) fsm_q <= S_IDLE;
    else         fsm_q <= fsm_d;
  end

  // Next-state logic. Without the S-box stage the final-round decision is
  // made one cycle earlier, on the index the round is about to advance to.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE, S_DONE: if (bus.load) fsm_d = S_INIT;
      S_INIT: begin
        if (SBOX_SYNC)              fsm_d = S_SB;
        else if (NR_IDX == 4'd1)    fsm_d = S_FINAL;
        else                        fsm_d = S_RND;
      end
      S_SB:    fsm_d = (round_idx_q == NR_IDX) ? S_FINAL : S_RND;
      S_RND: begin
        if (SBOX_SYNC)                               fsm_d = S_SB;
        else if (round_idx_q + 4'd1 == NR_IDX)       fsm_d = S_FINAL;
        else                                         fsm_d = S_RND;
      end
      S_FINAL: fsm_d = S_DONE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (fsm_q)
      S_INIT, S_SB, S_RND, S_FINAL: bus.busy = 1'b1;
      S_DONE:                       bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.cyphertext = cyph_q;
  assign bus.round_idx  = round_idx_q;

  // Datapath registers. The load cycle parks plaintext/key in state/rk;
  // INIT then performs the initial addRoundKey in place.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= '0;
      rk_q        <= '0;
      rcon_q      <= '0;
      round_idx_q <= '0;
      cyph_q      <= '0;
    end else begin
      case (fsm_q)
        S_IDLE, S_DONE: begin
          if (bus.load) begin
            state_q     <= bus.plaintext;
            rk_q        <= bus.key;
            rcon_q      <= 8'h01;
            round_idx_q <= 4'd0;
          end
        end
        S_INIT: begin
          state_q     <= state_q ^ rk_q;
          round_idx_q <= 4'd1;
        end
        S_RND, S_FINAL: begin
          state_q <= round_out;
          rk_q    <= next_rk;
          rcon_q  <= xtime(rcon_q);
          if (round_idx_q != NR_IDX) round_idx_q <= round_idx_q + 4'd1;
          if (fsm_q == S_FINAL)      cyph_q      <= round_out;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Directed bench for aes_round_ctrl. Two instances: registered
//               S-box (21-cycle latency) and combinational S-box (11 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_E  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_E  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam int NO_PULSE = -10;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if ifa ();
  aes_round_ctrl_if ifb ();

  aes_round_ctrl #(.NR(10), .SBOX_SYNC(1'b1)) dut_sync (
    .clk(clk), .nreset(nreset), .bus(ifa)
  );
  aes_round_ctrl #(.NR(10), .SBOX_SYNC(1'b0)) dut_comb (
    .clk(clk), .nreset(nreset), .bus(ifb)
  );

  bit           sel;   // 0: registered S-box instance, 1: combinational
  logic         obs_busy, obs_done;
  logic [127:0] obs_ct;
  logic [3:0]   obs_ridx;

  always_comb begin
    obs_busy = sel ? ifb.busy       : ifa.busy;
    obs_done = sel ? ifb.done       : ifa.done;
    obs_ct   = sel ? ifb.cyphertext : ifa.cyphertext;
    obs_ridx = sel ? ifb.round_idx  : ifa.round_idx;
  end

  int checks = 0;
  int errors = 0;
  int cyc;
  bit busy_ok;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic v);
    if (sel) ifb.load = v;
    else     ifa.load = v;
  endtask

  task automatic set_data(input logic [127:0] k, input logic [127:0] p);
    ifa.key = k; ifb.key = k;
    ifa.plaintext = p; ifb.plaintext = p;
  endtask

  // Present one load for one edge; returns just after the accepting edge.
  task automatic start(input logic [127:0] k, input logic [127:0] p);
    set_data(k, p);
    set_load(1'b1);
    tick();
    set_load(1'b0);
  endtask

  // Count edges from the accepting edge until done, bounded; optionally
  // pulse load (with different data) at a given cycle of the block.
  task automatic wait_done(input int pulse_at, output int n, output bit bok);
    n = 0;
    bok = 1'b1;
    while (obs_done !== 1'b1 && n < 60) begin
      if (obs_busy !== 1'b1) bok = 1'b0;
      if (n == pulse_at) begin
        set_data(KEY_C, PT_C);
        set_load(1'b1);
      end else if (n == pulse_at + 1) begin
        set_load(1'b0);
      end
      tick();
      n++;
    end
  endtask

  initial begin
    sel = 1'b0;
    ifa.load = 1'b0; ifb.load = 1'b0;
    set_data('0, '0);
    tick();
    tick();
    check("rst_busy", {127'd0, ifa.busy}, 128'd0);
    check("rst_done", {127'd0, ifa.done}, 128'd0);
    check("rst_ct", ifa.cyphertext, 128'd0);
    check("rst_ridx", {124'd0, ifa.round_idx}, 128'd0);
    check("rst_done_comb", {127'd0, ifb.done}, 128'd0);
    nreset = 1'b1;
    tick();

    // FIPS-197 App. B, registered S-box
    start(KEY_B, PT_B);
    check("B_busy_after_load", {127'd0, obs_busy}, 128'd1);
    check("B_ridx_after_load", {124'd0, obs_ridx}, 128'd0);
    tick();
    check("B_ridx_after_init", {124'd0, obs_ridx}, 128'd1);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("B_latency", 128'(cyc + 1), 128'd21);
    check("B_ct", obs_ct, CT_B);
    check("B_busy_at_done", {127'd0, obs_busy}, 128'd0);
    check("B_ridx_final", {124'd0, obs_ridx}, 128'd10);

    // Result held while idle in DONE
    repeat (3) tick();
    check("B_done_held", {127'd0, obs_done}, 128'd1);
    check("B_ct_held", obs_ct, CT_B);

    // App. C.1 loaded straight from DONE
    start(KEY_C, PT_C);
    check("C_done_drops", {127'd0, obs_done}, 128'd0);
    check("C_busy", {127'd0, obs_busy}, 128'd1);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("C_latency", 128'(cyc), 128'd21);
    check("C_ct", obs_ct, CT_C);

    // SP800-38A ECB vector
    start(KEY_B, PT_E);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("E_latency", 128'(cyc), 128'd21);
    check("E_ct", obs_ct, CT_E);

    // Load pulsed (with other data) at cycle 5 of an active block: ignored
    start(KEY_B, PT_B);
    wait_done(5, cyc, busy_ok);
    check("P_latency", 128'(cyc), 128'd21);
    check("P_ct", obs_ct, CT_B);
    check("P_busy_held", {127'd0, busy_ok}, 128'd1);

    // Reset dropped mid-block, then reload
    start(KEY_B, PT_B);
    repeat (9) tick();
    nreset = 1'b0;
    #1;
    check("R_busy_in_rst", {127'd0, obs_busy}, 128'd0);
    check("R_done_in_rst", {127'd0, obs_done}, 128'd0);
    check("R_ct_in_rst", obs_ct, 128'd0);
    check("R_ridx_in_rst", {124'd0, obs_ridx}, 128'd0);
    tick();
    nreset = 1'b1;
    tick();
    check("R_idle_done", {127'd0, obs_done}, 128'd0);
    start(KEY_B, PT_B);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("R_latency", 128'(cyc), 128'd21);
    check("R_ct", obs_ct, CT_B);

    // Combinational S-box instance: 11-cycle latency
    sel = 1'b1;
    start(KEY_B, PT_B);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("S0_B_latency", 128'(cyc), 128'd11);
    check("S0_B_ct", obs_ct, CT_B);
    check("S0_B_busy_held", {127'd0, busy_ok}, 128'd1);
    start(KEY_C, PT_C);
    check("S0_C_done_drops", {127'd0, obs_done}, 128'd0);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("S0_C_latency", 128'(cyc), 128'd11);
    check("S0_C_ct", obs_ct, CT_C);

    // Load held high: restarts on entry to DONE, capturing inputs then
    set_data(KEY_B, PT_E);
    set_load(1'b1);
    tick();
    set_data(KEY_B, PT_B);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("H_latency", 128'(cyc), 128'd11);
    check("H_ct_first", obs_ct, CT_E);
    tick();
    set_load(1'b0);
    check("H_done_one_cycle", {127'd0, obs_done}, 128'd0);
    check("H_busy_restart", {127'd0, obs_busy}, 128'd1);
    wait_done(NO_PULSE, cyc, busy_ok);
    check("H_latency2", 128'(cyc), 128'd11);
    check("H_ct_second", obs_ct, CT_B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
